// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register with a valid/ready handshake, synchronous
//   flush and an optional 2-entry skid buffer. With SKID=1, in_ready comes
//   straight from a flop, so a stall never ripples combinationally upstream.
//   With SKID=0 it is a single register whose in_ready follows out_ready.
//
// Parameters
//   WIDTH      payload width in bits (1..256)
//   RESET_VAL  value of out_data and of the skid data register after reset
//   SKID       1: 2-entry skid buffer, registered in_ready
//              0: single register, in_ready = ~out_valid | out_ready
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   flush      synchronous; drops every held entry and any coincident input
//   in_valid   upstream has data
//   in_ready   this stage accepts data this cycle
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   payload to the downstream stage
//   occupancy  number of held entries (0..2, at most 1 when SKID=0)
//
// State   | meaning
// --------+----------------------------------------------------------
// EMPTY   | nothing held (skid_valid=0, out_valid=0)
// FULL1   | one entry, in the output register (skid_valid=0, out_valid=1)
// FULL2   | two entries, oldest in output register, newest in skid register
//         | (skid_valid=1, out_valid=1); only reachable when SKID=1
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter bit                    SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding is {skid_valid, out_valid} so both flags come straight off the
  // state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] out_data_q, out_data_nxt;
  logic [WIDTH-1:0] skid_data_q, skid_data_nxt;
  logic             skid_valid;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid  = state_q[0];
  assign skid_valid = state_q[1];
  assign out_data   = out_data_q;
  assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};

  generate
    if (SKID) begin : g_ready_reg
      // Purely a flop output: no path from out_ready.
      assign in_ready = ~skid_valid;
    end else begin : g_ready_comb
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_data_q  <= RESET_VAL;
      skid_data_q <= RESET_VAL;
    end else begin
      state_q     <= state_nxt;
      out_data_q  <= out_data_nxt;
      skid_data_q <= skid_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    out_data_nxt  = out_data_q;
    skid_data_nxt = skid_data_q;

    if (flush) begin
      // Data registers hold; their contents are meaningless once invalid.
      state_nxt = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt    = FULL1;
            out_data_nxt = in_data;
          end
        end
        FULL1: begin
          if (in_xfer && out_xfer) begin
            out_data_nxt = in_data;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: with SKID=0 an input transfer
            // while full implies out_ready, handled above.
            state_nxt     = FULL2;
            skid_data_nxt = in_data;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL2: begin
          if (out_xfer) begin
            state_nxt    = FULL1;
            out_data_nxt = skid_data_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule
